melody_arbiter_ctrl: RTL and testbench

- Controller that shares one melody classifier between two players.
- Each player submits a 5-note word: 3-bit note code plus tom bit per note.
- Block arbitrates round-robin, clears the classifier, replays the word one note per cycle with ok strobes, then appends the terminator note 000.
- Waits for fim and returns tipo tagged with the player index. A timeout guard covers a classifier that never finishes.

---
 rtl/melody_arbiter_ctrl_pkg.sv | 47 ++++
 rtl/melody_arbiter_ctrl_rr.sv | 29 ++
 rtl/melody_arbiter_ctrl.sv | 149 ++++++++++++++
 tb/tb_melody_arbiter_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/melody_arbiter_ctrl_pkg.sv
// Shared constants for the two-player melody classifier controller:
// note/tipo codes, controller state encoding and word-slicing helpers.
package melody_arbiter_ctrl_pkg;

  localparam int unsigned NOTES = 5;

  localparam logic [2:0] NOTA_X = 3'b000;
  localparam logic [2:0] NOTA_DO = 3'b001;
  localparam logic [2:0] NOTA_RE = 3'b010;
  localparam logic [2:0] NOTA_MI = 3'b011;
  localparam logic [2:0] NOTA_FA = 3'b100;
  localparam logic [2:0] NOTA_SOL = 3'b101;
  localparam logic [2:0] NOTA_LA = 3'b110;
  localparam logic [2:0] NOTA_SI = 3'b111;

  localparam logic [1:0] TIPO_NULO = 2'b00;
  localparam logic [1:0] TIPO_ADJ = 2'b01;
  localparam logic [1:0] TIPO_COMP = 2'b10;
  localparam logic [1:0] TIPO_ADV = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED = 3'd2;
  localparam logic [2:0] S_TERM = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  // Out-of-range indices return 0 so the selects never run past the word.
  function automatic logic [2:0] note_at(input logic [14:0] w, input logic [2:0] k);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NOTES; i++) begin
      if (k == i[2:0]) n = w[3*i +: 3];
    end
    return n;
  endfunction

  function automatic logic tom_at(input logic [4:0] t, input logic [2:0] k);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < NOTES; i++) begin
      if (k == i[2:0]) b = t[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/melody_arbiter_ctrl_rr.sv
// Two-requester round-robin arbiter: the player not served last wins ties.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] ready_o,
  output logic       grant_o,
  output logic       fire_o
);

  logic last_q, last_d;
  logic pref;

  always_comb begin
    pref    = ~last_q;
    grant_o = req_i[pref] ? pref : ~pref;
    ready_o = '0;
    if (en_i && req_i[grant_o]) ready_o[grant_o] = 1'b1;
    fire_o  = |(ready_o & req_i);
    last_d  = fire_o ? grant_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/melody_arbiter_ctrl.sv
// Shares one melody classifier between two players: arbitrate, clear,
// replay the captured 5-note word plus terminator, then report tipo.
module melody_arbiter_ctrl
  import melody_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wd_valid,
  output logic [1:0]  wd_ready,
  input  logic [29:0] wd_notas,
  input  logic [9:0]  wd_toms,
  output logic        cls_reset,
  output logic        cls_ok,
  output logic [2:0]  cls_nota,
  output logic        cls_tom,
  input  logic        cls_fim,
  input  logic [1:0]  cls_tipo,
  output logic        res_valid,
  output logic        res_player,
  output logic [1:0]  res_tipo,
  output logic        res_timeout,
  output logic        busy
);

  logic [2:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            player_q, player_d;
  logic [14:0]     notes_q, notes_d;
  logic [4:0]      toms_q, toms_d;
  logic            res_player_q, res_player_d;
  logic [1:0]      res_tipo_q, res_tipo_d;
  logic            res_timeout_q, res_timeout_d;

  logic grant, fire, to_report;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    ((state_q == S_IDLE) && reset),
    .req_i   (wd_valid),
    .ready_o (wd_ready),
    .grant_o (grant),
    .fire_o  (fire)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    player_d      = player_q;
    notes_d       = notes_q;
    toms_d        = toms_q;
    res_player_d  = res_player_q;
    res_tipo_d    = res_tipo_q;
    res_timeout_d = res_timeout_q;
    to_report     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fire) begin
          notes_d  = grant ? wd_notas[29:15] : wd_notas[14:0];
          toms_d   = grant ? wd_toms[9:5] : wd_toms[4:0];
          player_d = grant;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_FEED;
      end
      S_FEED, S_TERM: begin
        // fim during replay means the classifier hit error; stop feeding.
        if (cls_fim) begin
          res_tipo_d    = cls_tipo;
          res_timeout_d = 1'b0;
          to_report     = 1'b1;
        end else if (state_q == S_TERM) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (idx_q == 3'(NOTES - 1)) begin
          state_d = S_TERM;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (cls_fim) begin
          res_tipo_d    = cls_tipo;
          res_timeout_d = 1'b0;
          to_report     = 1'b1;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          res_tipo_d    = TIPO_NULO;
          res_timeout_d = 1'b1;
          to_report     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (to_report) begin
      res_player_d = player_q;
      state_d      = S_REPORT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      player_q      <= 1'b0;
      notes_q       <= '0;
      toms_q        <= '0;
      res_player_q  <= 1'b0;
      res_tipo_q    <= TIPO_NULO;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      player_q      <= player_d;
      notes_q       <= notes_d;
      toms_q        <= toms_d;
      res_player_q  <= res_player_d;
      res_tipo_q    <= res_tipo_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    cls_reset   = ~reset | (state_q == S_CLEAR);
    cls_ok      = (state_q == S_FEED) || (state_q == S_TERM);
    cls_nota    = (state_q == S_FEED) ? note_at(notes_q, idx_q) : NOTA_X;
    cls_tom     = (state_q == S_FEED) ? tom_at(toms_q, idx_q) : 1'b0;
    res_valid   = (state_q == S_REPORT);
    res_player  = res_player_q;
    res_tipo    = res_tipo_q;
    res_timeout = res_timeout_q;
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_melody_arbiter_ctrl.sv
// Randomized bench for melody_arbiter_ctrl with a behavioural classifier stub
// and a cycle-timeline reference model of each word.
module tb_melody_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wd_valid, wd_ready;
  logic [29:0] wd_notas;
  logic [9:0]  wd_toms;
  logic        cls_reset, cls_ok, cls_tom, cls_fim;
  logic [2:0]  cls_nota;
  logic [1:0]  cls_tipo;
  logic        res_valid, res_player, res_timeout, busy;
  logic [1:0]  res_tipo;

  int checks = 0;
  int failures = 0;

  logic       last_p;
  logic       exp_rp;
  logic [1:0] exp_rt;
  logic       exp_rto;
  logic       hang;
  logic [1:0] stub_tipo;
  int         stub_cnt;

  always #5 clk = ~clk;

  melody_arbiter_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_notas(wd_notas), .wd_toms(wd_toms), .cls_reset(cls_reset),
    .cls_ok(cls_ok), .cls_nota(cls_nota), .cls_tom(cls_tom),
    .cls_fim(cls_fim), .cls_tipo(cls_tipo), .res_valid(res_valid),
    .res_player(res_player), .res_tipo(res_tipo),
    .res_timeout(res_timeout), .busy(busy)
  );

  // Classifier stub: errors on note 000 among the five word notes, finishes
  // with stub_tipo after the terminator, or never finishes when hang is set.
  always @(posedge clk) begin
    if (cls_reset) begin
      cls_fim  <= 1'b0;
      cls_tipo <= 2'b00;
      stub_cnt <= 0;
    end else if (!cls_fim && cls_ok) begin
      stub_cnt <= stub_cnt + 1;
      if (!hang && stub_cnt < 5 && cls_nota == 3'b000) begin
        cls_fim  <= 1'b1;
        cls_tipo <= 2'b00;
      end else if (!hang && stub_cnt == 5) begin
        cls_fim  <= 1'b1;
        cls_tipo <= stub_tipo;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_held();
    chk("res_player_held", 32'(res_player), 32'(exp_rp));
    chk("res_tipo_held", 32'(res_tipo), 32'(exp_rt));
    chk("res_timeout_held", 32'(res_timeout), 32'(exp_rto));
  endtask

  // Starts at a negedge; returns at the negedge of the IDLE cycle after REPORT.
  task automatic run_word(input logic [1:0] vmask, input logic hg,
                          input logic [1:0] tp, input int abort_at);
    logic       p, np;
    logic [14:0] en;
    logic [4:0]  et;
    logic [2:0]  nk;
    logic [1:0]  exp_ready, rtipo;
    logic        rto;
    int          z, r;
    logic        e_ok, e_tom;
    logic [2:0]  e_nota;

    wd_valid  = vmask;
    hang      = hg;
    stub_tipo = tp;
    np = ~last_p;
    p  = vmask[np] ? np : ~np;
    exp_ready = '0;
    exp_ready[p] = 1'b1;
    #1;
    chk("wd_ready_grant", 32'(wd_ready), 32'(exp_ready));
    en = p ? wd_notas[29:15] : wd_notas[14:0];
    et = p ? wd_toms[9:5] : wd_toms[4:0];
    z = 5;
    for (int k = 4; k >= 0; k--) begin
      nk = en[3*k +: 3];
      if (nk == 3'b000) z = k;
    end
    if (hg) begin
      r = 24; rtipo = 2'b00; rto = 1'b1;
    end else if (z < 5) begin
      r = 4 + z; rtipo = 2'b00; rto = 1'b0;
    end else begin
      r = 9; rtipo = tp; rto = 1'b0;
    end
    @(posedge clk);
    last_p = p;

    for (int n = 1; n <= r + 1; n++) begin
      @(negedge clk);
      e_ok   = (n >= 2) && (n < r) && (n <= 7);
      e_nota = ((n >= 2) && (n <= 6) && (n < r)) ? en[3*(n-2) +: 3] : 3'b000;
      e_tom  = ((n >= 2) && (n <= 6) && (n < r)) ? et[n-2] : 1'b0;
      if (n == r) begin
        exp_rp = p; exp_rt = rtipo; exp_rto = rto;
      end
      chk("cls_ok", 32'(cls_ok), 32'(e_ok));
      chk("cls_nota", 32'(cls_nota), 32'(e_nota));
      chk("cls_tom", 32'(cls_tom), 32'(e_tom));
      chk("cls_reset", 32'(cls_reset), 32'(n == 1));
      chk("busy", 32'(busy), 32'(n <= r));
      chk("res_valid", 32'(res_valid), 32'(n == r));
      if (n <= r) chk("wd_ready_busy", 32'(wd_ready), 32'd0);
      chk_held();
      if (n == 1) begin
        if (vmask != 2'b11) wd_valid = 2'b00;
        wd_notas = 30'($urandom());
        wd_toms  = 10'($urandom());
      end
      if (n == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        exp_rp = 1'b0; exp_rt = 2'b00; exp_rto = 1'b0;
        chk("abort_cls_reset", 32'(cls_reset), 32'd1);
        chk("abort_cls_ok", 32'(cls_ok), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_wd_ready", 32'(wd_ready), 32'd0);
        chk_held();
        last_p = 1'b1;
        reset  = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    wd_valid  = 2'b11;
    wd_notas  = {15'o75231, 15'o64321};
    wd_toms   = '0;
    hang      = 1'b0;
    stub_tipo = 2'b00;
    last_p    = 1'b1;
    exp_rp = 1'b0; exp_rt = 2'b00; exp_rto = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cls_ok", 32'(cls_ok), 32'd0);
    chk("rst_cls_nota", 32'(cls_nota), 32'd0);
    chk("rst_cls_reset", 32'(cls_reset), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_wd_ready", 32'(wd_ready), 32'd0);
    chk_held();
    reset = 1'b1;

    // Contention from reset release: grants 0,1,0; first word is do,re,mi,fa,la.
    run_word(2'b11, 1'b0, 2'b01, 0);
    run_word(2'b11, 1'b0, 2'b10, 0);
    run_word(2'b11, 1'b0, 2'b11, 0);

    // Player 1 first note 000: early error finish.
    wd_notas[29:15] = 15'o74520;
    run_word(2'b10, 1'b0, 2'b11, 0);

    // Classifier never finishes: timeout.
    wd_notas[14:0] = 15'o12345;
    run_word(2'b01, 1'b1, 2'b10, 0);

    // Reset during FEED index 2, then a fresh word.
    wd_notas[14:0] = 15'o76543;
    run_word(2'b01, 1'b0, 2'b01, 4);
    wd_notas[14:0] = 15'o23456;
    run_word(2'b01, 1'b0, 2'b10, 0);

    for (int i = 0; i < 12; i++) begin
      run_word(2'($urandom_range(1, 3)), ($urandom_range(0, 5) == 0),
               2'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
